uart_tx_framer: RTL and testbench



---
 rtl/uart_tx_framer.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_tx_framer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_framer.sv
// uart_tx_framer: serialises one DATA_WIDTH-bit word per request into an
// asynchronous serial frame. The frame is a start bit (0), the data bits LSB
// first, an optional parity bit and a stop bit (1). The parity value comes
// from an external parity calculator.
//
// Every line bit starts and ends on a baud_tick strobe, so each bit lasts
// exactly one baud period. After an accept the framer waits in LOAD for the
// next tick, so the start bit is never shortened.
//
// Build option:
//   UART_TX_TWO_STOP_BITS_EN  when defined, a second stop bit (STOP2) follows
//                             STOP, and frame_done moves one tick later.
module uart_tx_framer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  baud_tick,
  input  logic                  data_valid,
  input  logic [DATA_WIDTH-1:0] parallel_data,
  input  logic                  parity_enable,
  input  logic                  parity_bit,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  frame_done
);

  // The counter indexes the data bits 0..DATA_WIDTH-1. It stops at the last
  // index, so it never wraps. A one-bit payload still gets a 1-bit counter.
  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_DATA,
    S_PARITY,
`ifdef UART_TX_TWO_STOP_BITS_EN
    S_STOP,
    S_STOP2
`else
    S_STOP
`endif
  } state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]        cnt_q,   cnt_d;
  logic                    flag_q,  flag_d;
  logic                    tx_q,    tx_d;
  logic                    busy_q,  busy_d;
  logic                    done_q,  done_d;
  logic [DATA_WIDTH-1:0]   shift_nx;
  logic                    last_bit;

  assign shift_nx = shift_q >> 1;
  assign last_bit = (cnt_q == LAST_BIT);

  // State register. An asynchronous reset aborts any frame in progress.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: clocked state uses non-blocking assignments, so every register
    // samples the values from before the edge, whatever the order of the blocks.
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Outside IDLE, the state only moves on a baud tick.
  always_comb begin
    // NOTE: a default assignment comes first in every combinational block.
    // A path that does not assign a variable would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (data_valid) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (baud_tick) begin
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_tick) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_tick && last_bit) begin
          state_d = flag_q ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (baud_tick) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (baud_tick) begin
`ifdef UART_TX_TWO_STOP_BITS_EN
          state_d = S_STOP2;
`else
          state_d = S_IDLE;
`endif
        end
      end
`ifdef UART_TX_TWO_STOP_BITS_EN
      S_STOP2: begin
        if (baud_tick) begin
          state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath logic. This block computes the next value of the
  // serial line, the status flags and the shift register, counter and flag.
  always_comb begin
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    flag_d  = flag_q;
    unique case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        // A request is taken only here. While busy, new requests are
        // ignored and the latched word and flag stay unchanged.
        if (data_valid) begin
          shift_d = parallel_data;
          flag_d  = parity_enable;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_LOAD: begin
        // The line stays idle until the next tick. This aligns the start bit
        // to a full baud period.
        if (baud_tick) begin
          tx_d = 1'b0;
        end
      end
      S_START: begin
        if (baud_tick) begin
          tx_d  = shift_q[0];
          cnt_d = '0;
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          if (last_bit) begin
            // The parity value is captured on the edge that enters PARITY.
            // It then stays fixed for the whole parity bit.
            tx_d = flag_q ? parity_bit : 1'b1;
          end else begin
            shift_d = shift_nx;
            cnt_d   = cnt_q + CNT_W'(1);
            tx_d    = shift_nx[0];
          end
        end
      end
      S_PARITY: begin
        if (baud_tick) begin
          tx_d = 1'b1;
        end
      end
      S_STOP: begin
        if (baud_tick) begin
          tx_d = 1'b1;
`ifndef UART_TX_TWO_STOP_BITS_EN
          busy_d = 1'b0;
          done_d = 1'b1;
`endif
        end
      end
`ifdef UART_TX_TWO_STOP_BITS_EN
      S_STOP2: begin
        if (baud_tick) begin
          tx_d   = 1'b1;
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
`endif
      default: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers. The line idles high through reset.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: the shift register, counter and flag are cleared by reset like the
    // control state, so an aborted frame leaves nothing behind.
    if (!reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx_out     = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Testbench for uart_tx_framer. When a frame is requested, the expected line
// bits are pushed to a queue. Each baud tick then pops one bit and compares
// it with tx_out. A free-running baud strobe fires every BAUD clocks.
// Build with UART_TX_TWO_STOP_BITS_EN to expect the second stop bit.
module tb_uart_tx_framer;

  localparam int DW   = 8;
  localparam int BAUD = 4;
`ifdef UART_TX_TWO_STOP_BITS_EN
  localparam int N_STOP = 2;
`else
  localparam int N_STOP = 1;
`endif

  logic          clk           = 1'b0;
  logic          reset         = 1'b1;
  logic          baud_tick     = 1'b0;
  logic          data_valid    = 1'b0;
  logic [DW-1:0] parallel_data = '0;
  logic          parity_enable = 1'b0;
  logic          parity_bit    = 1'b0;
  logic          tx_out;
  logic          busy;
  logic          frame_done;

  int   pass_cnt   = 0;
  int   total_cnt  = 0;
  int   glitch_cnt = 0;
  logic exp_q[$];

  uart_tx_framer #(.DATA_WIDTH(DW)) dut (
    .clk           (clk),
    .reset         (reset),
    .baud_tick     (baud_tick),
    .data_valid    (data_valid),
    .parallel_data (parallel_data),
    .parity_enable (parity_enable),
    .parity_bit    (parity_bit),
    .tx_out        (tx_out),
    .busy          (busy),
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;

  // Baud strobe: high for one rising edge out of every BAUD.
  int baud_div = 0;
  always @(negedge clk) begin
    baud_div  = (baud_div == BAUD - 1) ? 0 : baud_div + 1;
    baud_tick = (baud_div == BAUD - 1);
  end

  // Glitch monitor: outside reset, tx_out may only change after a ticked edge.
  logic tick_at_edge = 1'b0;
  logic tx_prev      = 1'b1;
  always @(posedge clk) tick_at_edge = baud_tick;
  always @(negedge clk) begin
    if (reset === 1'b1 && tx_out !== tx_prev && !tick_at_edge) glitch_cnt++;
    tx_prev = tx_out;
  end

  // Watchdog: guarantees the run ends even if a wait never returns.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: the expected line bits of one frame.
  task automatic push_frame(input logic [DW-1:0] d, input logic pe, input logic pb);
    exp_q.push_back(1'b0);
    for (int i = 0; i < DW; i++) exp_q.push_back(d[i]);
    if (pe) exp_q.push_back(pb);
    for (int i = 0; i < N_STOP; i++) exp_q.push_back(1'b1);
  endtask

  // Drives a one-clock request. Call it at a falling edge; it returns at the
  // falling edge after the accept.
  task automatic start_frame(input logic [DW-1:0] d, input logic pe, input logic pb);
    parallel_data = d;
    parity_enable = pe;
    parity_bit    = pb;
    data_valid    = 1'b1;
    push_frame(d, pe, pb);
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  // Waits for n baud ticks. ok is 0 if a wait runs out of time.
  task automatic wait_ticks(input int n, output bit ok);
    int guard;
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      guard = 0;
      do begin @(posedge clk); guard++; end
      while (baud_tick !== 1'b1 && guard < 8 * BAUD);
      if (baud_tick !== 1'b1) ok = 1'b0;
    end
  endtask

  // Counts the clocks, out of clks, where the line is not idle or busy is set.
  task automatic count_not_idle(input int clks, output int bad);
    bad = 0;
    for (int i = 0; i < clks; i++) begin
      @(negedge clk);
      if (tx_out !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) bad++;
    end
  endtask

  // Scoreboard drain: on each tick, pops one expected bit and compares the
  // line. At the end it checks the single frame_done pulse.
  task automatic drain(input string tag);
    bit   ok;
    logic b;
    int   idx;
    idx = 0;
    while (exp_q.size() > 0) begin
      wait_ticks(1, ok);
      if (!ok) begin
        total_cnt++;
        $display("FAIL %s tick_timeout bit=%0d", tag, idx);
        exp_q.delete();
        return;
      end
      @(negedge clk);
      b = exp_q.pop_front();
      total_cnt++;
      if (tx_out !== b) $display("FAIL %s line_bit%0d tx_out=%b expected=%b", tag, idx, tx_out, b);
      else pass_cnt++;
      total_cnt++;
      if (busy !== 1'b1) $display("FAIL %s busy_bit%0d busy=%b expected=1", tag, idx, busy);
      else pass_cnt++;
      total_cnt++;
      if (frame_done !== 1'b0) $display("FAIL %s early_done_bit%0d frame_done=%b expected=0", tag, idx, frame_done);
      else pass_cnt++;
      idx++;
    end
    wait_ticks(1, ok);
    if (!ok) begin
      total_cnt++;
      $display("FAIL %s tick_timeout at stop exit", tag);
      return;
    end
    @(negedge clk);
    total_cnt++;
    if (frame_done !== 1'b1) $display("FAIL %s done_pulse frame_done=%b expected=1", tag, frame_done);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL %s busy_after busy=%b expected=0", tag, busy);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (frame_done !== 1'b0) $display("FAIL %s done_width frame_done=%b expected=0", tag, frame_done);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    int bad;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (tx_out !== 1'b1) $display("FAIL reset_tx tx_out=%b expected=1", tx_out);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_busy busy=%b expected=0", busy);
    else pass_cnt++;
    total_cnt++;
    if (frame_done !== 1'b0) $display("FAIL reset_done frame_done=%b expected=0", frame_done);
    else pass_cnt++;
    reset = 1'b1;
    count_not_idle(3 * BAUD, bad);
    total_cnt++;
    if (bad !== 0) $display("FAIL reset_idle not_idle_clocks=%0d expected=0", bad);
    else pass_cnt++;
  endtask

  task automatic test_no_parity();
    @(negedge clk);
    start_frame(8'hA5, 1'b0, 1'b0);
    drain("a5_nopar");
  endtask

  task automatic test_parity();
    @(negedge clk);
    start_frame(8'hA5, 1'b1, 1'b1);
    drain("a5_par1");
    @(negedge clk);
    start_frame(8'hA5, 1'b1, 1'b0);
    drain("a5_par0");
  endtask

  task automatic test_busy_ignore();
    bit ok;
    int bad;
    ok = 1'b1;
    @(negedge clk);
    start_frame(8'hFF, 1'b0, 1'b0);
    fork
      drain("ff_busy");
      begin
        wait_ticks(5, ok);
        @(negedge clk);
        parallel_data = 8'h3C;
        parity_enable = 1'b1;
        data_valid    = 1'b1;
        repeat (2) @(negedge clk);
        data_valid    = 1'b0;
        parallel_data = 8'hFF;
        parity_enable = 1'b0;
      end
    join
    if (!ok) begin
      total_cnt++;
      $display("FAIL busy_ignore tick_timeout");
    end
    count_not_idle(4 * BAUD, bad);
    total_cnt++;
    if (bad !== 0) $display("FAIL busy_ignore_no_3c not_idle_clocks=%0d expected=0", bad);
    else pass_cnt++;
  endtask

  task automatic test_stop_exit_ignore();
    bit ok;
    int bad;
    ok = 1'b1;
    @(negedge clk);
    start_frame(8'h55, 1'b0, 1'b0);
    fork
      drain("stop_exit");
      begin
        // Ticks: 1 enters START, 1+DW enters the last data bit, and N_STOP
        // more ticks reach the last stop bit. The next tick exits.
        wait_ticks(1 + DW + N_STOP, ok);
        repeat (BAUD) @(negedge clk);
        parallel_data = 8'h0F;
        data_valid    = 1'b1;
        @(negedge clk);
        data_valid    = 1'b0;
      end
    join
    if (!ok) begin
      total_cnt++;
      $display("FAIL stop_exit tick_timeout");
    end
    count_not_idle(4 * BAUD, bad);
    total_cnt++;
    if (bad !== 0) $display("FAIL stop_exit_ignored not_idle_clocks=%0d expected=0", bad);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int bad;
    @(negedge clk);
    start_frame(8'hA5, 1'b0, 1'b0);
    exp_q.delete();
    // Ticks: 1 start, 2 bit0, 3 bit1, 4 bit2, 5 bit3 (bit3 of 0xA5 is 0).
    wait_ticks(5, ok);
    if (!ok) begin
      total_cnt++;
      $display("FAIL reset_mid tick_timeout");
    end
    @(negedge clk);
    total_cnt++;
    if (tx_out !== 1'b0) $display("FAIL reset_mid_bit3 tx_out=%b expected=0", tx_out);
    else pass_cnt++;
    #2 reset = 1'b0;
    #1;
    total_cnt++;
    if (tx_out !== 1'b1) $display("FAIL reset_mid_tx tx_out=%b expected=1", tx_out);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_mid_busy busy=%b expected=0", busy);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    count_not_idle(3 * BAUD, bad);
    total_cnt++;
    if (bad !== 0) $display("FAIL reset_mid_discard not_idle_clocks=%0d expected=0", bad);
    else pass_cnt++;
    start_frame(8'h01, 1'b0, 1'b0);
    drain("after_reset_01");
  endtask

  task automatic test_back_to_back();
    int g0;
    g0 = glitch_cnt;
    @(negedge clk);
    start_frame(8'hC3, 1'b0, 1'b0);
    drain("b2b_first");
    // drain returns at the falling edge one clock after the frame_done pulse.
    start_frame(8'h5A, 1'b1, 1'b0);
    drain("b2b_second");
    total_cnt++;
    if (glitch_cnt !== g0) $display("FAIL b2b_glitch glitches=%0d expected=%0d", glitch_cnt, g0);
    else pass_cnt++;
  endtask

  task automatic test_zero_frame();
    @(negedge clk);
    start_frame(8'h00, 1'b0, 1'b0);
    drain("zero_frame");
  endtask

  initial begin
    test_reset();
    test_no_parity();
    test_parity();
    test_busy_ignore();
    test_stop_exit_ignore();
    test_reset_mid();
    test_back_to_back();
    test_zero_frame();
    total_cnt++;
    if (glitch_cnt !== 0) $display("FAIL line_glitch glitches=%0d expected=0", glitch_cnt);
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
